// File: rtl/draw_pkg.sv
// Shared types and constants for the VGA draw stages (paddle, ball).
// Holds timing/position widths, width-select codes, colours and the flash FSM state type.
package draw_pkg;

  localparam int TIM_W = 11;
  localparam int POS_W = 12;
  localparam int RGB_W = 12;

  localparam logic [1:0] SEL_NORMAL = 2'b00;
  localparam logic [1:0] SEL_NARROW = 2'b01;
  localparam logic [1:0] SEL_WIDE   = 2'b10;

  localparam logic [RGB_W-1:0] COL_FILL   = 12'hF00;
  localparam logic [RGB_W-1:0] COL_BORDER = 12'hFFF;
  localparam logic [RGB_W-1:0] COL_FLASH  = 12'hFF0;

  typedef enum logic {
    FLASH_IDLE   = 1'b0,
    FLASH_ACTIVE = 1'b1
  } flash_state_e;

  // Undefined code 2'b11 falls back to the normal width.
  function automatic logic [POS_W-1:0] decode_width(
    input logic [1:0]       sel,
    input logic [POS_W-1:0] w_narrow,
    input logic [POS_W-1:0] w_normal,
    input logic [POS_W-1:0] w_wide
  );
    case (sel)
      SEL_NARROW: decode_width = w_narrow;
      SEL_WIDE:   decode_width = w_wide;
      default:    decode_width = w_normal;
    endcase
  endfunction

endpackage

// File: rtl/draw_paddle_ctl_if.sv
// VGA pixel-stream bundle: timing counters, sync/blank flags and pixel colour.
interface draw_paddle_ctl_if;
  import draw_pkg::*;

  logic [TIM_W-1:0] hcount;
  logic             hsync;
  logic             hblnk;
  logic [TIM_W-1:0] vcount;
  logic             vsync;
  logic             vblnk;
  logic [RGB_W-1:0] rgb;

  modport master (output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
  modport slave  (input  hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);

endinterface

// File: rtl/vga_timing_delay.sv
// Fixed-length delay line for the VGA timing signals, shared by the draw stages.
module vga_timing_delay
  import draw_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TIM_W-1:0] hcount_in,
  input  logic             hsync_in,
  input  logic             hblnk_in,
  input  logic [TIM_W-1:0] vcount_in,
  input  logic             vsync_in,
  input  logic             vblnk_in,
  output logic [TIM_W-1:0] hcount_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic [TIM_W-1:0] vcount_out,
  output logic             vsync_out,
  output logic             vblnk_out
);

  localparam int BW = 2 * TIM_W + 4;

  logic [BW-1:0] pipe_q [STAGES];
  logic [BW-1:0] pipe_d [STAGES];

  always_comb begin
    pipe_d[0] = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in};
    for (int i = 1; i < STAGES; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        pipe_q[i] <= {BW{1'b0}};
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out} = pipe_q[STAGES-1];

endmodule

// File: rtl/draw_paddle_ctl.sv
// Player paddle renderer: bordered rectangle with per-frame shadowed position/width
// and a hit-triggered flash, inserted into the pixel stream with a 2-cycle latency.
module draw_paddle_ctl
  import draw_pkg::*;
#(
  parameter int               W_NARROW     = 100,
  parameter int               W_NORMAL     = 200,
  parameter int               W_WIDE       = 300,
  parameter int               HEIGHT       = 20,
  parameter int               BORDER       = 2,
  parameter logic [RGB_W-1:0] COLOR        = COL_FILL,
  parameter logic [RGB_W-1:0] BORDER_COLOR = COL_BORDER,
  parameter logic [RGB_W-1:0] FLASH_COLOR  = COL_FLASH,
  parameter int               FLASH_FRAMES = 8
) (
  input  logic             pclk,
  input  logic             reset_n,
  draw_paddle_ctl_if.slave  vga_in,
  draw_paddle_ctl_if.master vga_out,
  input  logic [POS_W-1:0] x_pos,
  input  logic [POS_W-1:0] y_pos,
  input  logic [1:0]       width_sel,
  input  logic             hit,
  output logic             on_paddle,
  output logic             flashing
);

  logic             vblnk_prev_q;
  logic [POS_W-1:0] x_s_q, x_s_d, y_s_q, y_s_d, w_s_q, w_s_d;
  logic             vblank_edge_s;

  logic [12:0] h13_s, v13_s, x13_s, y13_s, x_end_s, y_end_s;
  logic        in_rect_s, in_border_s, blank_s;

  logic             rect1_q, rect1_d, border1_q, border1_d;
  logic [RGB_W-1:0] rgb1_q, rgb1_d;

  flash_state_e state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         phase_q, phase_d;

  logic [RGB_W-1:0] fill_s, rgb_out_q, rgb_out_d;
  logic             on_paddle_q, on_paddle_d, flashing_q, flashing_d;

  assign vblank_edge_s = vga_in.vblnk & ~vblnk_prev_q;

  // Shadow registers only move at the start of vertical blank so a frame never tears.
  always_comb begin
    if (vblank_edge_s) begin
      x_s_d = x_pos;
      y_s_d = y_pos;
      w_s_d = decode_width(width_sel, POS_W'(W_NARROW), POS_W'(W_NORMAL), POS_W'(W_WIDE));
    end else begin
      x_s_d = x_s_q;
      y_s_d = y_s_q;
      w_s_d = w_s_q;
    end
  end

  // 13-bit arithmetic so x+w never wraps; off-screen parts are simply never reached.
  always_comb begin
    h13_s   = {2'b00, vga_in.hcount};
    v13_s   = {2'b00, vga_in.vcount};
    x13_s   = {1'b0, x_s_q};
    y13_s   = {1'b0, y_s_q};
    x_end_s = x13_s + {1'b0, w_s_q};
    y_end_s = y13_s + 13'(HEIGHT);
    blank_s = vga_in.hblnk | vga_in.vblnk;
    in_rect_s = (h13_s >= x13_s) && (h13_s < x_end_s) &&
                (v13_s >= y13_s) && (v13_s < y_end_s);
    in_border_s = (h13_s < x13_s + 13'(BORDER)) || (h13_s + 13'(BORDER) >= x_end_s) ||
                  (v13_s < y13_s + 13'(BORDER)) || (v13_s + 13'(BORDER) >= y_end_s);
    rect1_d   = in_rect_s & ~blank_s;
    border1_d = in_border_s;
    rgb1_d    = vga_in.rgb;
  end

  // Flash FSM: a hit always (re)loads the counter, even on a vblank edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    case (state_q)
      FLASH_IDLE: begin
        if (hit) begin
          state_d = FLASH_ACTIVE;
          cnt_d   = 8'(FLASH_FRAMES);
          phase_d = 1'b1;
        end else begin
          state_d = FLASH_IDLE;
        end
      end
      FLASH_ACTIVE: begin
        if (hit) begin
          cnt_d   = 8'(FLASH_FRAMES);
          phase_d = 1'b1;
        end else if (vblank_edge_s) begin
          cnt_d   = cnt_q - 8'd1;
          phase_d = ~phase_q;
          if (cnt_q == 8'd1) begin
            state_d = FLASH_IDLE;
          end else begin
            state_d = FLASH_ACTIVE;
          end
        end else begin
          state_d = FLASH_ACTIVE;
        end
      end
      default: begin
        state_d = FLASH_IDLE;
        cnt_d   = 8'd0;
        phase_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    if ((state_q == FLASH_ACTIVE) && phase_q) begin
      fill_s = FLASH_COLOR;
    end else begin
      fill_s = COLOR;
    end
    if (rect1_q) begin
      rgb_out_d = border1_q ? BORDER_COLOR : fill_s;
    end else begin
      rgb_out_d = rgb1_q;
    end
    on_paddle_d = rect1_q;
    flashing_d  = (state_q == FLASH_ACTIVE);
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      vblnk_prev_q <= 1'b0;
      x_s_q        <= {POS_W{1'b0}};
      y_s_q        <= {POS_W{1'b0}};
      w_s_q        <= POS_W'(W_NORMAL);
      rect1_q      <= 1'b0;
      border1_q    <= 1'b0;
      rgb1_q       <= {RGB_W{1'b0}};
      state_q      <= FLASH_IDLE;
      cnt_q        <= 8'd0;
      phase_q      <= 1'b0;
      rgb_out_q    <= {RGB_W{1'b0}};
      on_paddle_q  <= 1'b0;
      flashing_q   <= 1'b0;
    end else begin
      vblnk_prev_q <= vga_in.vblnk;
      x_s_q        <= x_s_d;
      y_s_q        <= y_s_d;
      w_s_q        <= w_s_d;
      rect1_q      <= rect1_d;
      border1_q    <= border1_d;
      rgb1_q       <= rgb1_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      rgb_out_q    <= rgb_out_d;
      on_paddle_q  <= on_paddle_d;
      flashing_q   <= flashing_d;
    end
  end

  vga_timing_delay #(.STAGES(2)) u_delay (
    .clk        (pclk),
    .rst_n      (reset_n),
    .hcount_in  (vga_in.hcount),
    .hsync_in   (vga_in.hsync),
    .hblnk_in   (vga_in.hblnk),
    .vcount_in  (vga_in.vcount),
    .vsync_in   (vga_in.vsync),
    .vblnk_in   (vga_in.vblnk),
    .hcount_out (vga_out.hcount),
    .hsync_out  (vga_out.hsync),
    .hblnk_out  (vga_out.hblnk),
    .vcount_out (vga_out.vcount),
    .vsync_out  (vga_out.vsync),
    .vblnk_out  (vga_out.vblnk)
  );

  assign vga_out.rgb = rgb_out_q;
  assign on_paddle   = on_paddle_q;
  assign flashing    = flashing_q;

endmodule

// File: tb/tb_draw_paddle_ctl.sv
// Bench for draw_paddle_ctl: directed vector table plus randomized pixels checked
// against a frame-level reference model through a 2-deep expectation queue.
module tb_draw_paddle_ctl;

  localparam int HEIGHT = 20;
  localparam int BORDER = 2;
  localparam int FFRAMES = 8;

  logic pclk = 1'b0;
  logic reset_n = 1'b0;
  always #5 pclk = ~pclk;

  draw_paddle_ctl_if in_if ();
  draw_paddle_ctl_if out_if ();

  logic [11:0] x_pos = 12'd0, y_pos = 12'd0;
  logic [1:0]  width_sel = 2'b00;
  logic        hit = 1'b0;
  logic        on_paddle, flashing;

  draw_paddle_ctl dut (
    .pclk      (pclk),
    .reset_n   (reset_n),
    .vga_in    (in_if),
    .vga_out   (out_if),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .width_sel (width_sel),
    .hit       (hit),
    .on_paddle (on_paddle),
    .flashing  (flashing)
  );

  typedef struct {
    logic [10:0] hc, vc;
    logic        hs, hb, vs, vb;
    logic [11:0] rgb;
    logic        on, fl;
    string       name;
  } exp_t;

  typedef struct {
    int          h, v;
    bit          hb, vb;
    logic [11:0] rgb, ergb;
    bit          eon;
    string       name;
  } vec_t;

  exp_t exp_q[$];
  vec_t tab[$];
  int tests = 0, fails = 0;

  // requested (pending) controls, applied on the next driven cycle
  int px = 0, py = 0, psel = 0;
  // reference model: frame-level shadow + flash bookkeeping
  int m_x, m_y, m_w, m_left, m_since;
  bit m_prev;

  function automatic int width_of(input int sel);
    case (sel)
      1: return 100;
      2: return 300;
      default: return 200;
    endcase
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_w = 200; m_left = 0; m_since = 0; m_prev = 1'b0;
  endtask

  task automatic check_out(input exp_t e);
    tests++;
    if (out_if.rgb !== e.rgb || on_paddle !== e.on || flashing !== e.fl ||
        out_if.hcount !== e.hc || out_if.vcount !== e.vc || out_if.hsync !== e.hs ||
        out_if.hblnk !== e.hb || out_if.vsync !== e.vs || out_if.vblnk !== e.vb) begin
      fails++;
      $display("FAIL %s: got rgb=%h on=%b fl=%b hc=%0d vc=%0d tim=%b%b%b%b, want rgb=%h on=%b fl=%b hc=%0d vc=%0d tim=%b%b%b%b",
               e.name, out_if.rgb, on_paddle, flashing, out_if.hcount, out_if.vcount,
               out_if.hsync, out_if.hblnk, out_if.vsync, out_if.vblnk,
               e.rgb, e.on, e.fl, e.hc, e.vc, e.hs, e.hb, e.vs, e.vb);
    end
  endtask

  task automatic check_zero(input string name);
    tests++;
    if (out_if.rgb !== 12'h000 || on_paddle !== 1'b0 || flashing !== 1'b0 ||
        out_if.hcount !== 11'd0 || out_if.vcount !== 11'd0 || out_if.hsync !== 1'b0 ||
        out_if.hblnk !== 1'b0 || out_if.vsync !== 1'b0 || out_if.vblnk !== 1'b0) begin
      fails++;
      $display("FAIL %s: outputs rgb=%h on=%b fl=%b hc=%0d vc=%0d, required all zero",
               name, out_if.rgb, on_paddle, flashing, out_if.hcount, out_if.vcount);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  // Drive one cycle (no clock wait): retire the oldest expectation, apply inputs, predict.
  task automatic step(input int h, input int v, input bit hb, input bit vb, input bit hit_i,
                      input logic [11:0] rgb, input bit use_tab, input logic [11:0] trgb,
                      input bit ton, input string name);
    exp_t e;
    bit edge_v, rect, brd, yel;
    if (exp_q.size() >= 2) check_out(exp_q.pop_front());
    in_if.hcount = 11'(h);
    in_if.vcount = 11'(v);
    in_if.hblnk  = hb;
    in_if.vblnk  = vb;
    in_if.hsync  = (h % 7 == 0);
    in_if.vsync  = vb && (v % 3 == 0);
    in_if.rgb    = rgb;
    x_pos = 12'(px); y_pos = 12'(py); width_sel = 2'(psel); hit = hit_i;

    edge_v = vb && !m_prev;
    m_prev = vb;
    rect = !(hb || vb) && h >= m_x && h < m_x + m_w && v >= m_y && v < m_y + HEIGHT;
    brd  = (h - m_x < BORDER) || (m_x + m_w - 1 - h < BORDER) ||
           (v - m_y < BORDER) || (m_y + HEIGHT - 1 - v < BORDER);
    if (hit_i) begin
      m_left = FFRAMES; m_since = 0;
    end else if (edge_v && m_left > 0) begin
      m_left--; m_since++;
    end
    yel = (m_left > 0) && (m_since % 2 == 0);

    e.hc = 11'(h); e.vc = 11'(v); e.hs = in_if.hsync; e.vs = in_if.vsync;
    e.hb = hb; e.vb = vb; e.fl = (m_left > 0); e.name = name;
    if (use_tab) begin
      e.rgb = trgb; e.on = ton;
    end else begin
      e.on  = rect;
      e.rgb = !rect ? rgb : (brd ? 12'hFFF : (yel ? 12'hFF0 : 12'hF00));
    end
    if (edge_v) begin
      m_x = px; m_y = py; m_w = width_of(psel);
    end
    exp_q.push_back(e);
  endtask

  task automatic cycle(input int h, input int v, input bit hb, input bit vb, input bit hit_i,
                       input logic [11:0] rgb, input bit use_tab, input logic [11:0] trgb,
                       input bit ton, input string name);
    @(negedge pclk);
    step(h, v, hb, vb, hit_i, rgb, use_tab, trgb, ton, name);
  endtask

  task automatic pix(input int h, input int v, input logic [11:0] rgb, input string name);
    cycle(h, v, 1'b0, 1'b0, 1'b0, rgb, 1'b0, 12'h000, 1'b0, name);
  endtask

  task automatic tpix(input int h, input int v, input logic [11:0] rgb,
                      input logic [11:0] ergb, input bit eon, input string name);
    cycle(h, v, 1'b0, 1'b0, 1'b0, rgb, 1'b1, ergb, eon, name);
  endtask

  task automatic vblank_edge();
    cycle(0, 600, 1'b1, 1'b1, 1'b0, 12'h0C3, 1'b0, 12'h000, 1'b0, "vblank");
    cycle(5, 600, 1'b1, 1'b1, 1'b0, 12'h0C4, 1'b0, 12'h000, 1'b0, "vblank");
    cycle(9, 0, 1'b1, 1'b0, 1'b0, 12'h0C5, 1'b0, 12'h000, 1'b0, "vblank_end");
  endtask

  task automatic do_reset();
    exp_t z;
    @(negedge pclk);
    #1 reset_n = 1'b0;
    #1 check_zero("reset_async");
    exp_q.delete();
    repeat (4) begin
      @(negedge pclk);
      in_if.hcount = 11'($urandom); in_if.vcount = 11'($urandom);
      in_if.rgb = 12'($urandom); in_if.hblnk = 1'($urandom); in_if.vblnk = 1'($urandom);
      hit = 1'($urandom);
      check_zero("reset_hold");
    end
    @(negedge pclk);
    reset_n = 1'b1;
    model_reset();
    z = '{hc: 11'd0, vc: 11'd0, hs: 1'b0, hb: 1'b0, vs: 1'b0, vb: 1'b0,
          rgb: 12'h000, on: 1'b0, fl: 1'b0, name: "pipe_zero"};
    exp_q.push_back(z);
    exp_q.push_back(z);
    step(5, 5, 1'b0, 1'b0, 1'b0, 12'h0A5, 1'b0, 12'h000, 1'b0, "post_reset");
  endtask

  initial begin
    int h, v;
    bit vbs;
    in_if.hcount = 11'd0; in_if.vcount = 11'd0; in_if.hsync = 1'b0; in_if.hblnk = 1'b0;
    in_if.vsync = 1'b0; in_if.vblnk = 1'b0; in_if.rgb = 12'h000;
    model_reset();

    // reset, then pass-through / default paddle at (0,0) width 200
    do_reset();
    for (int i = 0; i < 20; i++) pix($urandom_range(0, 260), $urandom_range(0, 30), 12'($urandom), "reset_default");

    // geometry at x=100 y=500 normal width
    px = 100; py = 500; psel = 0;
    vblank_edge();
    tab.push_back('{99,  500, 1'b0, 1'b0, 12'h123, 12'h123, 1'b0, "geo_left_out"});
    tab.push_back('{100, 500, 1'b0, 1'b0, 12'h124, 12'hFFF, 1'b1, "geo_left_edge"});
    tab.push_back('{102, 500, 1'b0, 1'b0, 12'h125, 12'hFFF, 1'b1, "geo_top_border"});
    tab.push_back('{299, 500, 1'b0, 1'b0, 12'h126, 12'hFFF, 1'b1, "geo_right_edge"});
    tab.push_back('{300, 500, 1'b0, 1'b0, 12'h127, 12'h127, 1'b0, "geo_right_out"});
    tab.push_back('{102, 510, 1'b0, 1'b0, 12'h128, 12'hF00, 1'b1, "geo_fill"});
    tab.push_back('{101, 505, 1'b0, 1'b0, 12'h129, 12'hFFF, 1'b1, "geo_left_border"});
    tab.push_back('{298, 505, 1'b0, 1'b0, 12'h12A, 12'hFFF, 1'b1, "geo_right_border"});
    tab.push_back('{297, 505, 1'b0, 1'b0, 12'h12B, 12'hF00, 1'b1, "geo_right_fill"});
    tab.push_back('{150, 517, 1'b0, 1'b0, 12'h12C, 12'hF00, 1'b1, "geo_bottom_fill"});
    tab.push_back('{150, 518, 1'b0, 1'b0, 12'h12D, 12'hFFF, 1'b1, "geo_bottom_border"});
    tab.push_back('{150, 519, 1'b0, 1'b0, 12'h12E, 12'hFFF, 1'b1, "geo_last_line"});
    tab.push_back('{150, 520, 1'b0, 1'b0, 12'h12F, 12'h12F, 1'b0, "geo_below"});
    tab.push_back('{150, 499, 1'b0, 1'b0, 12'h130, 12'h130, 1'b0, "geo_above"});
    tab.push_back('{150, 510, 1'b1, 1'b0, 12'h131, 12'h131, 1'b0, "geo_hblank"});
    foreach (tab[i])
      cycle(tab[i].h, tab[i].v, tab[i].hb, tab[i].vb, 1'b0, tab[i].rgb, 1'b1,
            tab[i].ergb, tab[i].eon, tab[i].name);

    // frame latch: new x only after the next vblank edge
    px = 400;
    tpix(150, 505, 12'h201, 12'hF00, 1'b1, "latch_old_frame");
    tpix(450, 505, 12'h202, 12'h202, 1'b0, "latch_old_right");
    vblank_edge();
    tpix(150, 505, 12'h203, 12'h203, 1'b0, "latch_new_left");
    tpix(450, 505, 12'h204, 12'hF00, 1'b1, "latch_new_frame");

    // width modes at x=400
    psel = 1; vblank_edge();
    tpix(499, 510, 12'h301, 12'hFFF, 1'b1, "narrow_last");
    tpix(500, 510, 12'h302, 12'h302, 1'b0, "narrow_out");
    psel = 2; vblank_edge();
    tpix(699, 510, 12'h303, 12'hFFF, 1'b1, "wide_last");
    tpix(700, 510, 12'h304, 12'h304, 1'b0, "wide_out");
    psel = 3; vblank_edge();
    tpix(599, 510, 12'h305, 12'hFFF, 1'b1, "sel11_last");
    tpix(600, 510, 12'h306, 12'h306, 1'b0, "sel11_out");

    // flash: yellow until first edge, alternating, extended by a hit at frame 5
    px = 100; psel = 0; vblank_edge();
    cycle(150, 510, 1'b0, 1'b0, 1'b1, 12'h401, 1'b0, 12'h000, 1'b0, "flash_hit");
    tpix(150, 510, 12'h402, 12'hFF0, 1'b1, "flash_yellow");
    tpix(100, 510, 12'h403, 12'hFFF, 1'b1, "flash_border");
    for (int f = 1; f <= 14; f++) begin
      vblank_edge();
      pix(150, 510, 12'h404, "flash_frame");
      pix(100, 512, 12'h405, "flash_frame_border");
      if (f == 1) tpix(160, 510, 12'h406, 12'hF00, 1'b1, "flash_alt_red");
      if (f == 2) tpix(160, 510, 12'h407, 12'hFF0, 1'b1, "flash_alt_yellow");
      if (f == 5) cycle(150, 510, 1'b0, 1'b0, 1'b1, 12'h408, 1'b0, 12'h000, 1'b0, "flash_rehit");
      pix(170, 511, 12'h409, "flash_settle");
      if (f == 12) check_bit("flash_still_on_f12", flashing, 1'b1);
      if (f == 13) check_bit("flash_off_f13", flashing, 1'b0);
    end

    // hit, then reset mid-frame: everything clears and paddle returns to (0,0) width 200
    cycle(150, 510, 1'b0, 1'b0, 1'b1, 12'h501, 1'b0, 12'h000, 1'b0, "pre_reset_hit");
    pix(150, 510, 12'h502, "pre_reset_flash");
    pix(150, 511, 12'h503, "pre_reset_flash");
    do_reset();
    tpix(150, 10, 12'h504, 12'hF00, 1'b1, "rst_default_fill");
    tpix(0, 0, 12'h505, 12'hFFF, 1'b1, "rst_default_corner");
    tpix(200, 5, 12'h506, 12'h506, 1'b0, "rst_default_out");
    tpix(150, 510, 12'h507, 12'h507, 1'b0, "rst_old_pos_gone");

    // clipping near the right edge, no wrap to h=0; vertical blanking pass-through
    px = 1000; py = 300; psel = 2; vblank_edge();
    tpix(0, 305, 12'h601, 12'h601, 1'b0, "clip_h0");
    tpix(3, 305, 12'h602, 12'h602, 1'b0, "clip_h3");
    tpix(1100, 310, 12'h603, 12'hF00, 1'b1, "clip_fill");
    tpix(1299, 310, 12'h604, 12'hFFF, 1'b1, "clip_right");
    tpix(1300, 310, 12'h605, 12'h605, 1'b0, "clip_out");
    cycle(1100, 310, 1'b0, 1'b1, 1'b0, 12'h606, 1'b1, 12'h606, 1'b0, "clip_vblank");
    cycle(1100, 310, 1'b0, 1'b0, 1'b0, 12'h607, 1'b1, 12'hF00, 1'b1, "clip_after_vblank");

    // randomized traffic against the model
    vbs = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        px = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 1400));
        py = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 700));
        psel = $urandom_range(0, 3);
      end
      if ($urandom_range(0, 39) == 0) vbs = ~vbs;
      if ($urandom_range(0, 1) == 0) begin
        h = m_x - 3 + int'($urandom_range(0, m_w + 6));
        v = m_y - 3 + int'($urandom_range(0, HEIGHT + 6));
      end else begin
        h = $urandom_range(0, 2047);
        v = $urandom_range(0, 2047);
      end
      if (h < 0) h = 0;
      if (v < 0) v = 0;
      if (h > 2047) h = 2047;
      if (v > 2047) v = 2047;
      cycle(h, v, ($urandom_range(0, 7) == 0), vbs, ($urandom_range(0, 59) == 0),
            12'($urandom), 1'b0, 12'h000, 1'b0, "random");
    end

    vbs = 1'b0;
    cycle(0, 0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, "flush");
    cycle(0, 0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, "flush");
    cycle(0, 0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, "flush");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
